iir_coef_loader: RTL and testbench

Writer side of the biquad IIR coefficient interface: accepts coefficient words over a valid/ready write port into a shadow bank.
On commit, it quiesces the filter, pulses its init, and atomically swaps the shadow bank into the active bank.
The active bank drives the filter's A1/A2/B0/B1/B2 coefficient inputs.
Sits between the control-register block and the IIR filter instance.

---
 rtl/iir_coef_pkg.sv | 24 ++
 rtl/iir_coef_bank.sv | 54 +++++
 rtl/iir_coef_loader.sv | 212 +++++++++++++++++++++
 tb/tb_iir_coef_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_coef_pkg.sv
// Shared constants and types for the biquad IIR coefficient loader.
//   COEF_A1..COEF_B2 : bank index of each coefficient
//   COEF_NUM         : number of coefficients per bank
//   IDX_W            : width of a coefficient address
//   CNT_W            : width of the DRAIN/INIT cycle counter
//   state_t          : commit sequencer states
package iir_coef_pkg;

    localparam int unsigned COEF_A1  = 0;
    localparam int unsigned COEF_A2  = 1;
    localparam int unsigned COEF_B0  = 2;
    localparam int unsigned COEF_B1  = 3;
    localparam int unsigned COEF_B2  = 4;
    localparam int unsigned COEF_NUM = 5;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        INIT  = 2'd2
    } state_t;

endpackage : iir_coef_pkg

// File: rtl/iir_coef_bank.sv
// Five-entry coefficient register bank.
// Optional readback port when IIR_COEF_READBACK_EN is defined.
//   clk, rst            : clock, async active-high reset (clears bank)
//   wr_en/wr_idx/wr_data: single-entry write (wr_idx must be legal when wr_en)
//   load_en/load_data   : bulk load of all entries, has priority over wr_en
//   q                   : current bank contents
//   rd_idx/rd_data_c    : combinational indexed read, 0 for illegal index
module iir_coef_bank
    import iir_coef_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [W-1:0]                  wr_data,
    input  logic                          load_en,
    input  logic [COEF_NUM-1:0][W-1:0]    load_data,
`ifdef IIR_COEF_READBACK_EN
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [W-1:0]                  rd_data_c,
`endif
    output logic [COEF_NUM-1:0][W-1:0]    q
);

    // Bank storage: bulk load wins over an indexed write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_data;
        end else if (wr_en) begin
            for (int i = 0; i < int'(COEF_NUM); i++) begin
                if (IDX_W'(i) == wr_idx) begin
                    q[i] <= wr_data;
                end
            end
        end
    end

`ifdef IIR_COEF_READBACK_EN
    // Indexed read; indices past the last coefficient read as zero.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < int'(COEF_NUM); i++) begin
            if (IDX_W'(i) == rd_idx) begin
                rd_data_c = q[i];
            end
        end
    end
`endif

endmodule : iir_coef_bank

// File: rtl/iir_coef_loader.sv
// Biquad IIR coefficient loader: collects coefficient writes in a shadow
// bank and, on commit, quiesces the filter, pulses init and swaps the shadow
// bank into the active bank that drives the filter.
// Optional feature macro: IIR_COEF_READBACK_EN (adds rd_addr/rd_sel/rd_data).
//   clk, rst              : clock, async active-high reset
//   wr_valid/wr_ready     : coefficient write handshake (ready only in IDLE)
//   wr_addr/wr_data       : 0=A1 1=A2 2=B0 3=B1 4=B2, 5..7 illegal
//   commit                : request to apply the shadow bank
//   run                   : filter enable request, sampled in IDLE only
//   busy                  : commit sequence in progress
//   addr_err/err_clr      : sticky illegal-address flag and its clear
//   A1..B2_coef           : active bank
//   filt_enable           : filter enable
//   filt_init_n           : filter init, active-low
//   shadow_dirty          : shadow written since last commit
//   rd_addr/rd_sel/rd_data: registered readback (0=active, 1=shadow)
module iir_coef_loader
    import iir_coef_pkg::*;
#(
    parameter int unsigned max_coef_width = 8,
    parameter int unsigned init_cycles    = 2,
    parameter int unsigned drain_cycles   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [IDX_W-1:0]            wr_addr,
    input  logic [max_coef_width-1:0]   wr_data,
    input  logic                        commit,
    input  logic                        run,
    output logic                        busy,
    output logic                        addr_err,
    input  logic                        err_clr,
`ifdef IIR_COEF_READBACK_EN
    input  logic [IDX_W-1:0]            rd_addr,
    input  logic                        rd_sel,
    output logic [max_coef_width-1:0]   rd_data,
`endif
    output logic [max_coef_width-1:0]   A1_coef,
    output logic [max_coef_width-1:0]   A2_coef,
    output logic [max_coef_width-1:0]   B0_coef,
    output logic [max_coef_width-1:0]   B1_coef,
    output logic [max_coef_width-1:0]   B2_coef,
    output logic                        filt_enable,
    output logic                        filt_init_n,
    output logic                        shadow_dirty
);

    localparam int unsigned W          = max_coef_width;
    localparam logic        SKIP_DRAIN = (drain_cycles == 0);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(drain_cycles - 1);
    localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(init_cycles - 1);

    state_t                     state, next_state;
    logic [CNT_W-1:0]           cnt, cnt_next;
    logic                       load_active;
    logic                       busy_d, filt_enable_d, filt_init_n_d;
    logic                       wr_acc, wr_legal, shadow_we;
    logic [COEF_NUM-1:0][W-1:0] shadow_q, shadow_post, active_q;

    assign wr_ready  = (state == IDLE);
    assign wr_acc    = wr_valid & wr_ready;
    assign wr_legal  = (wr_addr < IDX_W'(COEF_NUM));
    assign shadow_we = wr_acc & wr_legal;

    // Shadow contents including a same-cycle write, so a commit that lands
    // together with a write (and skips DRAIN) still swaps the new value.
    always_comb begin
        shadow_post = shadow_q;
        if (shadow_we) begin
            for (int i = 0; i < int'(COEF_NUM); i++) begin
                if (IDX_W'(i) == wr_addr) begin
                    shadow_post[i] = wr_data;
                end
            end
        end
    end

    // State and counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next state; active bank is loaded on the edge that enters INIT so new
    // coefficients are on the outputs during the first INIT cycle.
    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        load_active = 1'b0;
        unique case (state)
            IDLE: begin
                if (commit) begin
                    if (SKIP_DRAIN) begin
                        next_state  = INIT;
                        cnt_next    = INIT_LOAD;
                        load_active = 1'b1;
                    end else begin
                        next_state = DRAIN;
                        cnt_next   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    next_state  = INIT;
                    cnt_next    = INIT_LOAD;
                    load_active = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            INIT: begin
                if (cnt == '0) begin
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
        busy_d        = (next_state != IDLE);
        filt_enable_d = (next_state == IDLE) & run;
        filt_init_n_d = (next_state != INIT);
    end

    // Registered control outputs and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            filt_enable  <= 1'b0;
            filt_init_n  <= 1'b1;
            addr_err     <= 1'b0;
            shadow_dirty <= 1'b0;
        end else begin
            busy        <= busy_d;
            filt_enable <= filt_enable_d;
            filt_init_n <= filt_init_n_d;
            if (wr_acc && !wr_legal) begin
                addr_err <= 1'b1;
            end else if (err_clr) begin
                addr_err <= 1'b0;
            end
            if (load_active) begin
                shadow_dirty <= 1'b0;
            end else if (shadow_we) begin
                shadow_dirty <= 1'b1;
            end
        end
    end

`ifdef IIR_COEF_READBACK_EN
    logic [W-1:0] shadow_rd_c, active_rd_c;
`endif

    iir_coef_bank #(.W(W)) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (shadow_we),
        .wr_idx    (wr_addr),
        .wr_data   (wr_data),
        .load_en   (1'b0),
        .load_data ('0),
`ifdef IIR_COEF_READBACK_EN
        .rd_idx    (rd_addr),
        .rd_data_c (shadow_rd_c),
`endif
        .q         (shadow_q)
    );

    iir_coef_bank #(.W(W)) u_active (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .load_en   (load_active),
        .load_data (shadow_post),
`ifdef IIR_COEF_READBACK_EN
        .rd_idx    (rd_addr),
        .rd_data_c (active_rd_c),
`endif
        .q         (active_q)
    );

`ifdef IIR_COEF_READBACK_EN
    // Registered readback, one cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_sel ? shadow_rd_c : active_rd_c;
        end
    end
`endif

    assign A1_coef = active_q[COEF_A1];
    assign A2_coef = active_q[COEF_A2];
    assign B0_coef = active_q[COEF_B0];
    assign B1_coef = active_q[COEF_B1];
    assign B2_coef = active_q[COEF_B2];

endmodule : iir_coef_loader

// File: tb/tb_iir_coef_loader.sv
// Directed testbench for iir_coef_loader (drain_cycles=1, init_cycles=2).
module tb_iir_coef_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       run = 1'b0;
    logic       busy;
    logic       addr_err;
    logic       err_clr = 1'b0;
    logic [7:0] A1_coef, A2_coef, B0_coef, B1_coef, B2_coef;
    logic       filt_enable, filt_init_n, shadow_dirty;
`ifdef IIR_COEF_READBACK_EN
    logic [2:0] rd_addr = '0;
    logic       rd_sel = 1'b0;
    logic [7:0] rd_data;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    iir_coef_loader #(
        .max_coef_width (8),
        .init_cycles    (2),
        .drain_cycles   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit       (commit),
        .run          (run),
        .busy         (busy),
        .addr_err     (addr_err),
        .err_clr      (err_clr),
`ifdef IIR_COEF_READBACK_EN
        .rd_addr      (rd_addr),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
`endif
        .A1_coef      (A1_coef),
        .A2_coef      (A2_coef),
        .B0_coef      (B0_coef),
        .B1_coef      (B1_coef),
        .B2_coef      (B2_coef),
        .filt_enable  (filt_enable),
        .filt_init_n  (filt_init_n),
        .shadow_dirty (shadow_dirty)
    );

    // inputs: wv wa wd cm rn ec ; expected: busy rdy aerr fe fin dirty coefs
    typedef struct packed {
        logic       wv;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       cm;
        logic       rn;
        logic       ec;
        logic [5:0] st;   // {busy, wr_ready, addr_err, filt_enable, filt_init_n, shadow_dirty}
        logic [39:0] cf;  // {A1, A2, B0, B1, B2}
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] status();
        return {busy, wr_ready, addr_err, filt_enable, filt_init_n, shadow_dirty};
    endfunction

    function automatic logic [39:0] coefs();
        return {A1_coef, A2_coef, B0_coef, B1_coef, B2_coef};
    endfunction

    task automatic idle_inputs();
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        commit   = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        int n;
        //          wv wa    wd     cm rn ec  st(b r e fe fin d) cf
        vecs[0]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 6'b010110, 40'h00_00_00_00_00};
        vecs[1]  = '{1'b1, 3'd0, 8'h12, 1'b0, 1'b1, 1'b0, 6'b010111, 40'h00_00_00_00_00};
        vecs[2]  = '{1'b1, 3'd2, 8'h34, 1'b0, 1'b1, 1'b0, 6'b010111, 40'h00_00_00_00_00};
        vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 6'b100011, 40'h00_00_00_00_00};
        vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b100000, 40'h12_00_34_00_00};
        vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 6'b100000, 40'h12_00_34_00_00};
        vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 6'b010110, 40'h12_00_34_00_00};
        vecs[7]  = '{1'b1, 3'd6, 8'h99, 1'b0, 1'b1, 1'b0, 6'b011110, 40'h12_00_34_00_00};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 6'b010110, 40'h12_00_34_00_00};
        vecs[9]  = '{1'b1, 3'd7, 8'hAA, 1'b0, 1'b1, 1'b1, 6'b011110, 40'h12_00_34_00_00};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 6'b010110, 40'h12_00_34_00_00};
        vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b010010, 40'h12_00_34_00_00};
        vecs[12] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 6'b010110, 40'h12_00_34_00_00};

        // Reset values
        tick();
        tick();
        chk("reset_status", 64'(status()), 64'(6'b010010));
        chk("reset_coefs", 64'(coefs()), 64'h0);
        rst = 1'b0;

        // Table: basic writes, commit sequence timing, addr_err, run
        for (int i = 0; i < 13; i++) begin
            wr_valid = vecs[i].wv;
            wr_addr  = vecs[i].wa;
            wr_data  = vecs[i].wd;
            commit   = vecs[i].cm;
            run      = vecs[i].rn;
            err_clr  = vecs[i].ec;
            tick();
            chk($sformatf("vec%0d_status", i), 64'(status()), 64'(vecs[i].st));
            chk($sformatf("vec%0d_coefs", i), 64'(coefs()), 64'(vecs[i].cf));
        end
        idle_inputs();

        // Commit during busy is ignored; a write during busy waits for IDLE
        commit = 1'b1;
        tick();
        chk("busy_commit_start", 64'(busy), 64'(1));
        wr_valid = 1'b1;
        wr_addr  = 3'd3;
        wr_data  = 8'h56;
        chk("busy_wr_ready", 64'(wr_ready), 64'(0));
        n = 1;
        while (busy && n < 20) begin
            tick();
            commit = (n < 2);
            if (busy) n++;
        end
        commit = 1'b0;
        chk("busy_len_ignored_commit", 64'(n), 64'(3));
        chk("busy_write_not_yet", 64'({wr_ready, shadow_dirty}), 64'(2'b10));
        tick();
        wr_valid = 1'b0;
        chk("busy_write_accepted", 64'({busy, shadow_dirty, B1_coef}), 64'({1'b0, 1'b1, 8'h00}));
        tick();
        chk("no_queued_commit", 64'(busy), 64'(0));

        // Write coinciding with commit: commit takes the post-write shadow
        wr_valid = 1'b1;
        wr_addr  = 3'd4;
        wr_data  = 8'h7F;
        commit   = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        chk("wr_commit_status", 64'(status()), 64'(6'b010110));
        chk("wr_commit_coefs", 64'(coefs()), 64'h12_00_34_56_7F);

        // Reset asserted mid-INIT: everything back to reset values at once
        wr_valid = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 8'h21;
        tick();
        wr_valid = 1'b0;
        commit   = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("pre_rst_init", 64'({filt_init_n, A2_coef}), 64'({1'b0, 8'h21}));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_init_status", 64'(status()), 64'(6'b010010));
        chk("rst_init_coefs", 64'(coefs()), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_run", 64'(status()), 64'(6'b010110));

`ifdef IIR_COEF_READBACK_EN
        // Readback of shadow vs active
        wr_valid = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 8'h55;
        rd_sel   = 1'b1;
        rd_addr  = 3'd1;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("rd_shadow", 64'(rd_data), 64'h55);
        rd_sel = 1'b0;
        tick();
        chk("rd_active", 64'(rd_data), 64'h00);
        rd_sel  = 1'b1;
        rd_addr = 3'd6;
        tick();
        chk("rd_illegal", 64'(rd_data), 64'h00);
        commit  = 1'b1;
        rd_sel  = 1'b0;
        rd_addr = 3'd1;
        tick();
        commit = 1'b0;
        tick();
        tick();
        chk("rd_active_after_commit", 64'(rd_data), 64'h55);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_iir_coef_loader
